// File: rtl/cpu_multicycle.sv
//==============================================================================
// Module  : cpu_multicycle
// Brief   : Multi-cycle RV32I core (FETCH/DECODE/EXECUTE/MEM/WB) with a
//           ready/request data port and a memory-mapped GPIO register.
//           Optional feature macro: CPU_TRAP_EN (TRAP port + HALT state).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_multicycle #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          GPIO_WIDTH   = 32,
    parameter logic [31:0] GPIO_ADDR    = 32'h0000_1000,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [31:0]           INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] INSTRUCTION_ADDR,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [31:0]           RAM_WRITE_DATA,
    output logic                  RAM_WRITE_ENABLE,
    output logic                  RAM_REQ,
    input  logic                  RAM_READY,
    input  logic [31:0]           RAM_READ_DATA,
    output logic [GPIO_WIDTH-1:0] GPIO
`ifdef CPU_TRAP_EN
    ,
    output logic                  TRAP
`endif
);

    localparam int PC_W = ADDR_WIDTH + 2;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
`ifdef CPU_TRAP_EN
        ,
        S_HALT    = 3'd5
`endif
    } state_t;

    state_t                r_state;
    logic [PC_W-1:0]       r_pc;
    logic [PC_W-1:0]       r_next_pc;
    logic [31:0]           r_ir;
    logic [31:0]           r_rs1;
    logic [31:0]           r_rs2;
    logic [31:0]           r_result;
    logic                  r_wr_en;
    logic                  r_is_load;
    logic                  r_is_store;
    logic                  r_is_gpio;
    logic [31:0]           r_rf [32];
    logic                  r_ram_req;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [31:0]           r_ram_wdata;
    logic [GPIO_WIDTH-1:0] r_gpio;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_alt;
    logic [31:0]     w_pc32;
    logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0]     w_alu_b;
    logic [4:0]      w_shamt;
    logic [31:0]     w_alu;
    logic            w_taken;
    logic [31:0]     w_result;
    logic            w_wr;
    logic            w_jump;
    logic            w_load;
    logic            w_store;
    logic [31:0]     w_ea;
    logic            w_ea_gpio;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_next_pc;
`ifdef CPU_TRAP_EN
    logic            r_trap;
    logic            w_illegal;
    logic            w_bad_target;
`endif

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_alt    = r_ir[30];
    assign w_pc32   = 32'(r_pc);

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    assign w_alu_b = (w_opcode == c_OP_REG) ? r_rs2 : w_imm_i;
    assign w_shamt = w_alu_b[4:0];

    always_comb begin
        w_alu = 32'h0;
        case (w_funct3)
            3'b000:  w_alu = (w_opcode == c_OP_REG && w_alt) ? r_rs1 - w_alu_b : r_rs1 + w_alu_b;
            3'b001:  w_alu = r_rs1 << w_shamt;
            3'b010:  w_alu = {31'b0, $signed(r_rs1) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'b0, r_rs1 < w_alu_b};
            3'b100:  w_alu = r_rs1 ^ w_alu_b;
            3'b101:  w_alu = w_alt ? 32'($signed(r_rs1) >>> w_shamt) : r_rs1 >> w_shamt;
            3'b110:  w_alu = r_rs1 | w_alu_b;
            default: w_alu = r_rs1 & w_alu_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (r_rs1 == r_rs2);
            3'b001:  w_taken = (r_rs1 != r_rs2);
            3'b100:  w_taken = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  w_taken = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  w_taken = (r_rs1 <  r_rs2);
            3'b111:  w_taken = (r_rs1 >= r_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_result = w_alu;
        w_wr     = 1'b0;
        w_jump   = 1'b0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_target = '0;
        w_ea     = r_rs1 + w_imm_i;
`ifdef CPU_TRAP_EN
        w_illegal = 1'b0;
`endif
        case (w_opcode)
            c_OP_LUI: begin
                w_result = w_imm_u;
                w_wr     = 1'b1;
            end
            c_OP_AUIPC: begin
                w_result = w_pc32 + w_imm_u;
                w_wr     = 1'b1;
            end
            c_OP_JAL: begin
                w_result = w_pc32 + 32'd4;
                w_wr     = 1'b1;
                w_jump   = 1'b1;
                w_target = PC_W'(w_pc32 + w_imm_j);
            end
            c_OP_JALR: begin
                w_result = w_pc32 + 32'd4;
                w_wr     = 1'b1;
                w_jump   = 1'b1;
                w_target = PC_W'((r_rs1 + w_imm_i) & ~32'd1);
            end
            c_OP_BRANCH: begin
                w_jump   = w_taken;
                w_target = PC_W'(w_pc32 + w_imm_b);
            end
            c_OP_LOAD: begin
                w_load = 1'b1;
                w_wr   = 1'b1;
            end
            c_OP_STORE: begin
                w_store = 1'b1;
                w_ea    = r_rs1 + w_imm_s;
            end
            c_OP_IMM, c_OP_REG: w_wr = 1'b1;
            default: begin
`ifdef CPU_TRAP_EN
                w_illegal = 1'b1;
`endif
            end
        endcase
    end

    // Sub-word address bits never reach the PC or the GPIO decode.
    assign w_ea_gpio = ((w_ea & ~32'd3) == (GPIO_ADDR & ~32'd3));
    assign w_seq_pc  = PC_W'(w_pc32 + 32'd4);
    assign w_next_pc = (w_jump ? w_target : w_seq_pc) & ~PC_W'(3);
`ifdef CPU_TRAP_EN
    assign w_bad_target = w_jump & w_target[1];
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_VECTOR[PC_W-1:0];
            r_next_pc   <= '0;
            r_ir        <= 32'h0;
            r_rs1       <= 32'h0;
            r_rs2       <= 32'h0;
            r_result    <= 32'h0;
            r_wr_en     <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_gpio   <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'h0;
            r_gpio      <= '0;
`ifdef CPU_TRAP_EN
            r_trap      <= 1'b0;
`endif
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= INSTRUCTION;
                    r_rs1   <= r_rf[INSTRUCTION[19:15]];
                    r_rs2   <= r_rf[INSTRUCTION[24:20]];
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
`ifdef CPU_TRAP_EN
                    if (w_illegal || w_bad_target) begin
                        r_state <= S_HALT;
                        r_trap  <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        r_result   <= w_result;
                        r_wr_en    <= w_wr && (w_rd != 5'd0);
                        r_next_pc  <= w_next_pc;
                        r_is_load  <= w_load;
                        r_is_store <= w_store;
                        r_is_gpio  <= w_ea_gpio;
                        if (w_load || w_store) begin
                            r_state <= S_MEM;
                            if (!w_ea_gpio) begin
                                r_ram_req   <= 1'b1;
                                r_ram_we    <= w_store;
                                r_ram_addr  <= w_ea[ADDR_WIDTH+1:2];
                                r_ram_wdata <= r_rs2;
                            end
                        end else begin
                            r_state <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (r_is_gpio) begin
                        if (r_is_store) begin
                            r_gpio <= r_rs2[GPIO_WIDTH-1:0];
                        end else begin
                            r_result <= 32'(r_gpio);
                        end
                        r_state <= S_WB;
                    end else if (RAM_READY) begin
                        r_ram_req <= 1'b0;
                        r_ram_we  <= 1'b0;
                        if (r_is_load) begin
                            r_result <= RAM_READ_DATA;
                        end
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (r_wr_en) begin
                        r_rf[w_rd] <= r_result;
                    end
                    r_pc    <= r_next_pc;
                    r_state <= S_FETCH;
                end
`ifdef CPU_TRAP_EN
                S_HALT: r_state <= S_HALT;
`endif
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign INSTRUCTION_ADDR = r_pc[PC_W-1:2];
    assign RAM_ADDR         = r_ram_addr;
    assign RAM_WRITE_DATA   = r_ram_wdata;
    assign RAM_WRITE_ENABLE = r_ram_we;
    assign RAM_REQ          = r_ram_req;
    assign GPIO             = r_gpio;
`ifdef CPU_TRAP_EN
    assign TRAP             = r_trap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
//==============================================================================
// Module  : tb_cpu_multicycle
// Brief   : Directed program bench for cpu_multicycle with ROM and a RAM
//           responder of programmable latency. Honours CPU_TRAP_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_multicycle;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [9:0]  INSTRUCTION_ADDR;
    logic [9:0]  RAM_ADDR;
    logic [31:0] RAM_WRITE_DATA;
    logic        RAM_WRITE_ENABLE;
    logic        RAM_REQ;
    logic        RAM_READY = 1'b0;
    logic [31:0] RAM_READ_DATA = 32'h0;
    logic [31:0] GPIO;
`ifdef CPU_TRAP_EN
    logic        TRAP;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] rom [0:31];
    logic [31:0] ram [0:1023];
    int          ram_delay = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          req_good = 0;
    logic [9:0]  exp_addr = 10'd0;
    logic [31:0] exp_wdata = 32'h0;
    int          c;

    cpu_multicycle dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .INSTRUCTION      (INSTRUCTION),
        .INSTRUCTION_ADDR (INSTRUCTION_ADDR),
        .RAM_ADDR         (RAM_ADDR),
        .RAM_WRITE_DATA   (RAM_WRITE_DATA),
        .RAM_WRITE_ENABLE (RAM_WRITE_ENABLE),
        .RAM_REQ          (RAM_REQ),
        .RAM_READY        (RAM_READY),
        .RAM_READ_DATA    (RAM_READ_DATA),
        .GPIO             (GPIO)
`ifdef CPU_TRAP_EN
        ,
        .TRAP             (TRAP)
`endif
    );

    always #5 CLK = ~CLK;

    // Registered ROM: data for an address appears one cycle later.
    always @(posedge CLK) INSTRUCTION <= rom[INSTRUCTION_ADDR[4:0]];

    initial begin
        forever begin
            @(negedge CLK);
            if (RAM_REQ === 1'b1 && RAM_READY !== 1'b1) begin
                if (wait_cnt == ram_delay) begin
                    RAM_READY = 1'b1;
                    if (RAM_WRITE_ENABLE === 1'b1) ram[RAM_ADDR] = RAM_WRITE_DATA;
                    else RAM_READ_DATA = ram[RAM_ADDR];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                RAM_READY = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RAM_REQ === 1'b1) begin
                req_cycles++;
                if (RAM_ADDR === exp_addr && RAM_WRITE_DATA === exp_wdata &&
                    RAM_WRITE_ENABLE === 1'b1) req_good++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_addr(input logic [9:0] target, output int cyc);
        cyc = 0;
        while (INSTRUCTION_ADDR !== target && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (INSTRUCTION_ADDR !== target) begin
            total++;
            bad++;
            $error("FAIL timeout_addr: observed=%h expected=%h", INSTRUCTION_ADDR, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013;
        rom[0]  = 32'hFFB0_0093;  // addi x1,x0,-5
        rom[1]  = 32'h0010_3133;  // sltu x2,x0,x1
        rom[2]  = 32'h4010_D193;  // srai x3,x1,1
        rom[3]  = 32'h0010_2423;  // sw   x1,8(x0)
        rom[4]  = 32'h0080_2203;  // lw   x4,8(x0)
        rom[5]  = 32'h0000_12B7;  // lui  x5,0x1
        rom[6]  = 32'h0A50_0313;  // addi x6,x0,0xA5
        rom[7]  = 32'h0062_A023;  // sw   x6,0(x5)
        rom[8]  = 32'h0002_A383;  // lw   x7,0(x5)
        rom[9]  = 32'h0000_0093;  // addi x1,x0,0
        rom[10] = 32'h0030_0493;  // addi x9,x0,3
        rom[11] = 32'h0010_8093;  // addi x1,x1,1
        rom[12] = 32'h0015_0513;  // addi x10,x10,1
        rom[13] = 32'hFE90_9CE3;  // bne  x1,x9,-8
        rom[14] = 32'h0080_046F;  // jal  x8,+8
        rom[15] = 32'h0010_0593;  // addi x11,x0,1 (skipped)
        rom[16] = 32'h0000_007F;  // unknown opcode
        rom[17] = 32'h0070_0613;  // addi x12,x0,7
        rom[18] = 32'h0000_006F;  // jal  x0,0

        repeat (3) @(negedge CLK);
        check("rst_iaddr", 32'(INSTRUCTION_ADDR), 32'd0);
        check("rst_gpio", GPIO, 32'h0);
        check("rst_req", 32'(RAM_REQ), 32'd0);
        check("rst_we", 32'(RAM_WRITE_ENABLE), 32'd0);
        RESET_N = 1'b1;

        wait_addr(10'd1, c); check("addi_cycles", c, 32'd4);
        wait_addr(10'd2, c); check("sltu_cycles", c, 32'd4);
        wait_addr(10'd3, c); check("srai_cycles", c, 32'd4);
        check("x1_addi", dut.r_rf[1], 32'hFFFF_FFFB);
        check("x2_sltu", dut.r_rf[2], 32'h0000_0001);
        check("x3_srai", dut.r_rf[3], 32'hFFFF_FFFD);

        ram_delay  = 3;
        req_cycles = 0;
        req_good   = 0;
        exp_addr   = 10'd2;
        exp_wdata  = 32'hFFFF_FFFB;
        wait_addr(10'd4, c); check("sw_cycles", c, 32'd8);
        check("sw_req_cycles", req_cycles, 32'd4);
        check("sw_req_stable", req_good, 32'd4);
        check("sw_ram_data", ram[2], 32'hFFFF_FFFB);

        ram_delay = 0;
        wait_addr(10'd5, c); check("lw_cycles", c, 32'd5);
        check("x4_lw", dut.r_rf[4], 32'hFFFF_FFFB);

        wait_addr(10'd7, c);
        req_cycles = 0;
        wait_addr(10'd8, c); check("gpio_sw_cycles", c, 32'd5);
        check("gpio_value", GPIO, 32'h0000_00A5);
        check("gpio_sw_no_req", req_cycles, 32'd0);
        wait_addr(10'd9, c); check("gpio_lw_cycles", c, 32'd5);
        check("x7_gpio_lw", dut.r_rf[7], 32'h0000_00A5);

        wait_addr(10'd16, c);
        check("loop_x1", dut.r_rf[1], 32'd3);
        check("loop_body_x10", dut.r_rf[10], 32'd3);
        check("jal_link_x8", dut.r_rf[8], 32'h0000_003C);
        check("jal_skip_x11", dut.r_rf[11], 32'd0);

`ifdef CPU_TRAP_EN
        repeat (3) @(posedge CLK);
        #1;
        check("trap_set", 32'(TRAP), 32'd1);
        repeat (10) @(posedge CLK);
        #1;
        check("trap_pc_frozen", 32'(INSTRUCTION_ADDR), 32'd16);
        check("trap_held", 32'(TRAP), 32'd1);
        check("trap_no_x12", dut.r_rf[12], 32'd0);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("trap_cleared", 32'(TRAP), 32'd0);
        check("trap_rst_iaddr", 32'(INSTRUCTION_ADDR), 32'd0);
`else
        wait_addr(10'd17, c); check("nop_cycles", c, 32'd4);
        wait_addr(10'd18, c); check("after_nop_cycles", c, 32'd4);
        check("x12_after_nop", dut.r_rf[12], 32'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle RV32I integer core: successor to the single-module CPU stub, executing the base opcode classes (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) through a fetch/decode/execute/memory/writeback state machine. Sits between the instruction ROM and the data RAM. Adds a ready/request handshake on the data port and a memory-mapped GPIO register. Instruction and data address widths are configurable.

## Interface
- ADDR_WIDTH, 10: word-address width of the instruction and data ports.
- GPIO_WIDTH, 32: width of the GPIO output register, 1..32.
- GPIO_ADDR, 32'h0000_1000: byte address of the GPIO register. Loads and stores to it bypass the RAM.
- RESET_VECTOR, 32'h0: PC value on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  ROM data. Valid one cycle after INSTRUCTION_ADDR.
- INSTRUCTION_ADDR  out  ADDR_WIDTH  word address, PC[ADDR_WIDTH+1:2].
- RAM_ADDR  out  ADDR_WIDTH  data word address.
- RAM_WRITE_DATA  out  32  store data.
- RAM_WRITE_ENABLE  out  1  qualifies RAM_REQ as a write.
- RAM_REQ  out  1  data access request, held until RAM_READY.
- RAM_READY  in  1  access complete. Read data is valid on RAM_READ_DATA in the same cycle.
- RAM_READ_DATA  in  32  load data.
- GPIO  out  GPIO_WIDTH  GPIO register.
- TRAP  out  1  sticky illegal-instruction flag. Present only with CPU_TRAP_EN.

## Operation
- States: FETCH → DECODE → EXECUTE → MEM (loads/stores only) → WB → FETCH.
- FETCH: drive INSTRUCTION_ADDR from PC.
- DECODE: latch INSTRUCTION into IR. Read rs1 and rs2.
- EXECUTE: ALU result, branch decision, effective address.
- Register file: 32×32. x0 reads 0 and writes to x0 are discarded.
- R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- I-ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Shift amount is the low 5 bits. All arithmetic is mod 2^32.
- Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU. Taken target = PC + sext(imm_B).
- JAL: rd ← PC+4, PC ← PC + sext(imm_J).
- JALR: rd ← PC+4, PC ← (rs1 + sext(imm_I)) & ~1. Compute rd from the old PC before updating PC.
- LUI: rd ← imm_U. AUIPC: rd ← PC + imm_U.
- LOAD/STORE are word-only; funct3 is ignored. Effective address = rs1 + sext(imm). Bits [1:0] are ignored. RAM_ADDR = EA[ADDR_WIDTH+1:2].
- GPIO access (EA == GPIO_ADDR):
  - Store: GPIO ← rs2[GPIO_WIDTH-1:0] in MEM, RAM_REQ stays 0, MEM lasts 1 cycle.
  - Load: returns GPIO zero-extended to 32 bits.
- Non-branch instructions: PC ← PC+4. PC wraps modulo 2^(ADDR_WIDTH+2).
- Unknown opcode: treated as NOP (PC+4, no writes) unless CPU_TRAP_EN.

## Timing
- Reset values: PC = RESET_VECTOR, state = FETCH, all registers 0, IR 0. Outputs: RAM_REQ 0, RAM_WRITE_ENABLE 0, RAM_ADDR 0, RAM_WRITE_DATA 0, GPIO 0, TRAP 0. INSTRUCTION_ADDR = RESET_VECTOR[ADDR_WIDTH+1:2].
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB).
- RAM load/store: 5 + N cycles, where N = number of MEM cycles with RAM_READY low.
- GPIO load/store: 5 cycles.
- RAM handshake:
  - RAM_REQ, RAM_ADDR, RAM_WRITE_DATA and RAM_WRITE_ENABLE are registered on entry to MEM and held stable until the cycle RAM_READY = 1.
  - RAM_REQ deasserts on the next edge.
  - Load data is captured on the RAM_READY cycle.
  - RAM_READY while RAM_REQ = 0 is ignored.
- Register write and PC update occur on the WB→FETCH edge.
- Reset mid-access aborts immediately; RAM_REQ drops asynchronously.

## Configuration
- CPU_TRAP_EN defined:
  - An unknown opcode, or a misaligned taken branch/jump target (bit 1 set), enters state HALT.
  - TRAP = 1 in HALT. PC, registers and GPIO are frozen.
  - Only RESET_N leaves HALT.
- CPU_TRAP_EN undefined:
  - No TRAP port and no HALT state.
  - Unknown opcodes are NOPs. Target bits [1:0] are ignored.

## Test plan
- Reset → INSTRUCTION_ADDR = 0, GPIO = 0, RAM_REQ = 0. First fetch at word 0 one cycle after RESET_N rises.
- ADDI x1,x0,-5; SLTU x2,x0,x1; SRAI x3,x1,1 → x1 = 0xFFFFFFFB, x2 = 1, x3 = 0xFFFFFFFD. Each instruction takes 4 cycles.
- SW x1,8(x0) with RAM_READY delayed 3 cycles → RAM_ADDR = 2, RAM_WRITE_DATA = 0xFFFFFFFB held 4 cycles. Instruction totals 8 cycles. LW x4,8(x0) → x4 = 0xFFFFFFFB.
- LUI x5,0x1; ADDI x6,x0,0xA5; SW x6,0(x5) → GPIO = 0xA5 with no RAM_REQ. LW x7,0(x5) → x7 = 0xA5.
- BNE loop counting x1 from 0 to 3, then JAL x8,+8 → loop body runs 3 times. x8 = address of JAL + 4. The instruction after JAL is skipped.
- With CPU_TRAP_EN, opcode 0x7F → TRAP = 1 and PC frozen across 10 cycles. RESET_N low clears TRAP. Without the macro, the same instruction advances PC by 4.
